// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared definitions for the TDM link (transmit and receive).
//                Holds the frame-alignment state encoding and the default
//                frame geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Default frame geometry, shared with the transmit mux.
    localparam int C_DEF_NUM_CH = 4;
    localparam int C_DEF_DATA_W = 8;

    // Frame-alignment state of the receiver.
    typedef enum logic {
        ST_HUNT = 1'b0,   // waiting for a start-of-frame marker
        ST_RUN  = 1'b1    // aligned, assembling frames
    } state_t;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/demux_1xn.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1xn
//  Description : Combinational 1-to-N write-enable decoder. Asserts exactly
//                one output bit (the one addressed by sel) while en is high.
//                Receive-side mirror of the transmit channel mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1xn #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    // One comparator per output slot; out-of-range sel values select nothing.
    for (genvar k = 0; k < N; k++) begin : g_dec
        assign onehot[k] = en && (sel == SEL_W'(k));
    end

endmodule : demux_1xn
`default_nettype wire

// File: rtl/tdm_demux_deinterleaver.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_deinterleaver
//  Description : Receive end of the TDM link. Accepts one sample per valid
//                cycle, steers it into a per-channel shadow register and,
//                when the last channel of a frame arrives, publishes the whole
//                frame on ch_data with a one-cycle frame_valid strobe.
//                Aligns on in_sof, flags mid-frame in_sof with sync_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_deinterleaver
    import tdm_pkg::*;
#(
    parameter  int NUM_CH = C_DEF_NUM_CH,
    parameter  int DATA_W = C_DEF_DATA_W,
    localparam int CNT_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     frame_valid,
    output logic [CNT_W-1:0]         ch_sel,
    output logic                     locked,
    output logic                     sync_err
);

    localparam logic [CNT_W-1:0] C_LAST_CH = CNT_W'(NUM_CH - 1);

    state_t                         r_state;
    logic [CNT_W-1:0]               r_ch_sel;
    logic                           r_locked;
    logic                           r_frame_valid;
    logic                           r_sync_err;
    logic [NUM_CH*DATA_W-1:0]       r_ch_data;
    logic [NUM_CH-2:0][DATA_W-1:0]  r_shadow;

    logic                           w_accept;
    logic [CNT_W-1:0]               w_wr_sel;
    logic [NUM_CH-1:0]              w_we;

    // In HUNT only a start-of-frame sample is taken; in RUN every valid one.
    assign w_accept = in_valid && ((r_state == ST_RUN) || in_sof);

    // A start-of-frame sample always lands in slot 0, whatever the counter says.
    assign w_wr_sel = in_sof ? '0 : r_ch_sel;

    demux_1xn #(
        .N     (NUM_CH),
        .SEL_W (CNT_W)
    ) u_we_dec (
        .sel    (w_wr_sel),
        .en     (w_accept),
        .onehot (w_we)
    );

    // Shadow slots 0..NUM_CH-2 capture their sample; the last channel bypasses
    // the shadow and goes straight into ch_data together with the others.
    for (genvar k = 0; k < NUM_CH - 1; k++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_shadow[k] <= '0;
            end else if (w_we[k]) begin
                r_shadow[k] <= in_data;
            end
        end
    end

    // Alignment FSM, channel counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_ch_sel      <= '0;
            r_locked      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_ch_data     <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (in_valid && in_sof) begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                        r_ch_sel <= CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            // Realign: any partial frame is abandoned.
                            r_sync_err <= (r_ch_sel != '0);
                            r_ch_sel   <= CNT_W'(1);
                        end else if (w_we[NUM_CH-1]) begin
                            // Last channel: publish the whole frame at once.
                            r_ch_data     <= {in_data, r_shadow};
                            r_frame_valid <= 1'b1;
                            r_ch_sel      <= '0;
                        end else begin
                            r_ch_sel <= r_ch_sel + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                    r_ch_sel <= '0;
                end
            endcase
        end
    end

    assign ch_data     = r_ch_data;
    assign frame_valid = r_frame_valid;
    assign ch_sel      = r_ch_sel;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

    // Counter can only reach C_LAST_CH by incrementing, never beyond it.
    logic w_unused_last;
    assign w_unused_last = (C_LAST_CH == '0);

endmodule : tdm_demux_deinterleaver
`default_nettype wire

// File: tb/tb_tdm_demux_deinterleaver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_deinterleaver
//  Description : Directed self-checking bench for tdm_demux_deinterleaver
//                with NUM_CH=4, DATA_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_deinterleaver;

    localparam int C_NUM_CH = 4;
    localparam int C_DATA_W = 8;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         in_valid = 1'b0;
    logic                         in_sof = 1'b0;
    logic [C_DATA_W-1:0]          in_data = '0;
    logic [C_NUM_CH*C_DATA_W-1:0] ch_data;
    logic                         frame_valid;
    logic [1:0]                   ch_sel;
    logic                         locked;
    logic                         sync_err;

    int n_vec = 0;
    int n_err = 0;
    int fv_count = 0;
    int se_count = 0;

    tdm_demux_deinterleaver #(
        .NUM_CH (C_NUM_CH),
        .DATA_W (C_DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .ch_sel      (ch_sel),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then sample just after the clock edge.
    task automatic send(input logic v, input logic sof, input logic [7:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        if (frame_valid) fv_count++;
        if (sync_err)    se_count++;
        chk("fv_se_excl", 64'(frame_valid & sync_err), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ch_data"}, 64'(ch_data), 64'd0);
        chk({tag, "_fv"},      64'(frame_valid), 64'd0);
        chk({tag, "_se"},      64'(sync_err), 64'd0);
        chk({tag, "_locked"},  64'(locked), 64'd0);
        chk({tag, "_ch_sel"},  64'(ch_sel), 64'd0);
    endtask

    initial begin
        int fv0;
        // ---- 1: reset, then samples without sof ----
        rst_n = 1'b0;
        idle(2);
        chk_zero_outs("rst");
        rst_n = 1'b1;
        send(1'b1, 1'b0, 8'h11);
        send(1'b1, 1'b0, 8'h22);
        chk_zero_outs("hunt");

        // ---- 2: back-to-back frame ----
        send(1'b1, 1'b1, 8'hA0);
        chk("t2_locked", 64'(locked), 64'd1);
        chk("t2_sel1",   64'(ch_sel), 64'd1);
        send(1'b1, 1'b0, 8'hB1);
        chk("t2_sel2",   64'(ch_sel), 64'd2);
        send(1'b1, 1'b0, 8'hC2);
        chk("t2_sel3",   64'(ch_sel), 64'd3);
        chk("t2_nofv",   64'(frame_valid), 64'd0);
        send(1'b1, 1'b0, 8'hD3);
        chk("t2_fv",     64'(frame_valid), 64'd1);
        chk("t2_data",   64'(ch_data), 64'hD3C2B1A0);
        chk("t2_sel0",   64'(ch_sel), 64'd0);
        idle(1);
        chk("t2_fv_pulse", 64'(frame_valid), 64'd0);

        // ---- 3: same frame with 3-cycle gaps (sof without valid in gaps) ----
        fv0 = fv_count;
        send(1'b1, 1'b1, 8'hA0);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 8'hFF);
        chk("t3_sel_gap", 64'(ch_sel), 64'd1);
        send(1'b1, 1'b0, 8'hB1);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 8'hEE);
        send(1'b1, 1'b0, 8'hC2);
        idle(3);
        chk("t3_sel_hold", 64'(ch_sel), 64'd3);
        send(1'b1, 1'b0, 8'hD3);
        chk("t3_fv",   64'(frame_valid), 64'd1);
        chk("t3_data", 64'(ch_data), 64'hD3C2B1A0);
        idle(3);
        chk("t3_one_pulse", 64'(fv_count - fv0), 64'd1);
        chk("t3_no_se", 64'(se_count), 64'd0);

        // ---- 4: resync mid-frame ----
        send(1'b1, 1'b1, 8'h01);
        send(1'b1, 1'b0, 8'h02);
        chk("t4_se_pre", 64'(sync_err), 64'd0);
        send(1'b1, 1'b1, 8'h10);
        chk("t4_se",     64'(sync_err), 64'd1);
        chk("t4_sel1",   64'(ch_sel), 64'd1);
        chk("t4_locked", 64'(locked), 64'd1);
        send(1'b1, 1'b0, 8'h20);
        chk("t4_se_pulse", 64'(sync_err), 64'd0);
        send(1'b1, 1'b0, 8'h30);
        send(1'b1, 1'b0, 8'h40);
        chk("t4_fv",   64'(frame_valid), 64'd1);
        chk("t4_data", 64'(ch_data), 64'h40302010);
        chk("t4_se_cnt", 64'(se_count), 64'd1);

        // ---- 5: reset mid-frame ----
        fv0 = fv_count;
        send(1'b1, 1'b1, 8'h55);
        send(1'b1, 1'b0, 8'h66);
        send(1'b1, 1'b0, 8'h77);
        rst_n = 1'b0;
        send(1'b0, 1'b0, 8'h00);
        chk_zero_outs("t5_rst");
        rst_n = 1'b1;
        send(1'b1, 1'b0, 8'h88);
        chk("t5_hunt_locked", 64'(locked), 64'd0);
        chk("t5_no_fv", 64'(fv_count - fv0), 64'd0);
        send(1'b1, 1'b1, 8'h11);
        send(1'b1, 1'b0, 8'h22);
        send(1'b1, 1'b0, 8'h33);
        send(1'b1, 1'b0, 8'h44);
        chk("t5_fv",   64'(frame_valid), 64'd1);
        chk("t5_data", 64'(ch_data), 64'h44332211);

        // ---- 6: two frames back-to-back, second without sof ----
        fv0 = fv_count;
        send(1'b1, 1'b1, 8'h01);
        send(1'b1, 1'b0, 8'h02);
        send(1'b1, 1'b0, 8'h03);
        send(1'b1, 1'b0, 8'h04);
        chk("t6_fv1",   64'(frame_valid), 64'd1);
        chk("t6_data1", 64'(ch_data), 64'h04030201);
        send(1'b1, 1'b0, 8'h05);
        chk("t6_gap1", 64'(frame_valid), 64'd0);
        chk("t6_sel1", 64'(ch_sel), 64'd1);
        send(1'b1, 1'b0, 8'h06);
        send(1'b1, 1'b0, 8'h07);
        chk("t6_gap3", 64'(frame_valid), 64'd0);
        send(1'b1, 1'b0, 8'h08);
        chk("t6_fv2",   64'(frame_valid), 64'd1);
        chk("t6_data2", 64'(ch_data), 64'h08070605);
        chk("t6_cnt",   64'(fv_count - fv0), 64'd2);
        chk("t6_no_se", 64'(se_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_tdm_demux_deinterleaver
`default_nettype wire
